// File: rtl/complex_nr_accum_pkg.sv
// Shared definitions for the complex frame accumulator.
package complex_nr_accum_pkg;

    // Width of one real or imaginary part of the incoming complex product.
    localparam int RES_W = 16;

    // Frame FSM encoding: collecting products, or presenting a finished sum.
    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    // Smallest accumulator width that cannot overflow a full frame.
    function automatic int min_acc_w(input int acc_len);
        return RES_W + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/complex_acc_lane.sv
// One signed accumulator lane: sign-extends a product part, accumulates it,
// and captures the closing sum into a stable output register.
module complex_acc_lane
    import complex_nr_accum_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic             i_load,
    input  logic [RES_W-1:0] i_din,
    output logic [ACC_W-1:0] o_sum
);

    logic signed [ACC_W-1:0] w_sext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out;

    // A signed size cast sign-extends, and stays legal when ACC_W equals RES_W.
    assign w_sext = ACC_W'($signed(i_din));

    // The running sum including this cycle's sample; wraps modulo 2^ACC_W.
    assign w_sum  = r_acc + (i_add ? w_sext : '0);

    // Accumulate accepted samples and capture the final sum when the frame closes.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_add) begin
                r_acc <= w_sum;
            end
            if (i_load) begin
                r_out <= w_sum;
            end
        end
    end

    assign o_sum = r_out;

endmodule

// File: rtl/complex_nr_accum.sv
// Complex dot-product accumulator: sums ACC_LEN complex products per frame
// and presents the sum on a valid/ready port, stalling the producer meanwhile.
module complex_nr_accum
    import complex_nr_accum_pkg::*;
#(
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 18,
    parameter int CNT_W   = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sw_rst_i,
    input  logic             res_val_i,
    output logic             res_rdy_o,
    input  logic [RES_W-1:0] res_re_i,
    input  logic [RES_W-1:0] res_im_i,
    input  logic             flush_i,
    output logic             acc_val_o,
    input  logic             acc_rdy_i,
    output logic [ACC_W-1:0] acc_re_o,
    output logic [ACC_W-1:0] acc_im_o,
    output logic [CNT_W-1:0] acc_cnt_o
);

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_res_rdy;
    logic             r_acc_val;

    logic             w_rst;
    logic             w_accept;
    logic             w_last;
    logic             w_close;
    logic             w_release;
    logic [CNT_W-1:0] w_cnt_next;

    // Hardware and software reset have identical effect.
    assign w_rst      = rst_i | sw_rst_i;

    // r_res_rdy is only high in ACCUM, so an accept implies ACCUM.
    assign w_accept   = res_val_i & r_res_rdy;
    assign w_cnt_next = r_cnt + CNT_W'(w_accept);
    assign w_last     = (r_cnt == CNT_W'(ACC_LEN - 1));

    // Close on the frame's last sample, or on flush when the frame is non-empty
    // counting a sample accepted on the same edge.
    assign w_close    = (r_state == ST_ACCUM) &&
                        ((w_accept && w_last) || (flush_i && ((r_cnt != '0) || w_accept)));

    // The consumer taking the presented sum reopens the accumulator.
    assign w_release  = (r_state == ST_HOLD) && acc_rdy_i;

    // Frame FSM, sample counter and the registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state   <= ST_ACCUM;
            r_cnt     <= '0;
            r_acc_cnt <= '0;
            r_res_rdy <= 1'b1;
            r_acc_val <= 1'b0;
        end else if (r_state == ST_ACCUM) begin
            if (w_accept) begin
                r_cnt <= w_cnt_next;
            end
            if (w_close) begin
                r_state   <= ST_HOLD;
                r_acc_cnt <= w_cnt_next;
                r_res_rdy <= 1'b0;
                r_acc_val <= 1'b1;
            end
        end else begin
            if (w_release) begin
                r_state   <= ST_ACCUM;
                r_cnt     <= '0;
                r_res_rdy <= 1'b1;
                r_acc_val <= 1'b0;
            end
        end
    end

    complex_acc_lane #(.ACC_W(ACC_W)) u_lane_re (
        .i_clk  (clk_i),
        .i_rst  (w_rst),
        .i_clr  (w_release),
        .i_add  (w_accept),
        .i_load (w_close),
        .i_din  (res_re_i),
        .o_sum  (acc_re_o)
    );

    complex_acc_lane #(.ACC_W(ACC_W)) u_lane_im (
        .i_clk  (clk_i),
        .i_rst  (w_rst),
        .i_clr  (w_release),
        .i_add  (w_accept),
        .i_load (w_close),
        .i_din  (res_im_i),
        .o_sum  (acc_im_o)
    );

    assign res_rdy_o = r_res_rdy;
    assign acc_val_o = r_acc_val;
    assign acc_cnt_o = r_acc_cnt;

endmodule
